// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters (CPU, host), the arbiter
// and the single-port data memory. The arbiter connects through the slave modport.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: CPU has priority, the host
// is guaranteed a slot after MAX_WAIT consecutive denials. Read data returns one cycle after grant.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam logic [3:0] MaxWaitCnt = 4'(MAX_WAIT);

  logic              host_turn;
  logic              cpu_gnt;
  logic              host_gnt;

  logic [3:0]        wait_cnt_q,    wait_cnt_d;
  logic              cpu_rvalid_q,  cpu_rvalid_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q,   cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q,  host_rdata_d;

  // Grant stage: host wins when alone or once it has been starved MAX_WAIT cycles.
  always_comb begin
    host_turn = bus.host_req & (~bus.cpu_req | (wait_cnt_q == MaxWaitCnt));
    cpu_gnt   = rst_n & bus.cpu_req & ~host_turn;
    host_gnt  = rst_n & host_turn;
  end

  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.host_gnt  = host_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;

  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (cpu_gnt) begin
      bus.mem_re    = ~bus.cpu_we;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (host_gnt) begin
      bus.mem_re    = ~bus.host_we;
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
    end
  end

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!bus.host_req || host_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MaxWaitCnt) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Response stage: capture read data into the granted port's register.
  always_comb begin
    cpu_rvalid_d  = cpu_gnt & ~bus.cpu_we;
    host_rvalid_d = host_gnt & ~bus.host_we;
    cpu_rdata_d   = cpu_rvalid_d  ? bus.mem_rdata : cpu_rdata_q;
    host_rdata_d  = host_rvalid_d ? bus.mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q    <= '0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;

endmodule
